// File: rtl/ddr_read_phase_cal.sv
// Read-DQS phase calibration: sweeps 8 read-clock phases, finds the widest circular pass window, centres on it.
// Optional debug port pass_mask is enabled by defining DDR_CAL_DEBUG_EN.
module ddr_read_phase_cal #(
  parameter int unsigned SETTLE_CYCLES     = 64,
  parameter int unsigned STEP_PULSE_CYCLES = 4,
  parameter int unsigned TEST_TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pll_locked,
  output logic       phase_step,
  output logic       phase_updn,
  output logic       test_req,
  input  logic       test_ack,
  input  logic       test_pass,
  output logic       busy,
  output logic       done,
  output logic       cal_ok,
  output logic [2:0] best_phase,
  output logic [3:0] window_len
`ifdef DDR_CAL_DEBUG_EN
  ,
  output logic [7:0] pass_mask
`endif
);

  localparam int unsigned NUM_PHASES = 8;
  localparam int unsigned CNT_W      = 11;

  typedef enum logic [3:0] {
    IDLE, WAIT_LOCK, SETTLE, TEST, STEP_HI, STEP_LO, EVAL,
    MOVE_HI, MOVE_LO, MOVE_SETTLE, DONE, FAIL
  } state_t;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [2:0]              idx, idx_d;
  logic [2:0]              tracker, tracker_d;
  logic [NUM_PHASES-1:0]   mask, mask_d;
  logic [3:0]              scan_len, scan_len_d;
  logic [2:0]              scan_start, scan_start_d;
  logic [3:0]              cand;
  logic                    busy_d, done_d, cal_ok_d, updn_d, step_d, req_d;
  logic [2:0]              best_d;
  logic [3:0]              len_d;

  // Length of the circular run of ones in m beginning at position s.
  function automatic logic [3:0] run_len(input logic [7:0] m, input logic [2:0] s);
    logic [3:0] n;
    logic       stop;
    n    = '0;
    stop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!stop && m[s + 3'(k)]) n = n + 4'd1;
      else stop = 1'b1;
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      tracker    <= '0;
      mask       <= '0;
      scan_len   <= '0;
      scan_start <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cal_ok     <= 1'b0;
      best_phase <= '0;
      window_len <= '0;
      phase_updn <= 1'b0;
      phase_step <= 1'b0;
      test_req   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      tracker    <= tracker_d;
      mask       <= mask_d;
      scan_len   <= scan_len_d;
      scan_start <= scan_start_d;
      busy       <= busy_d;
      done       <= done_d;
      cal_ok     <= cal_ok_d;
      best_phase <= best_d;
      window_len <= len_d;
      phase_updn <= updn_d;
      phase_step <= step_d;
      test_req   <= req_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt + CNT_W'(1);
    idx_d        = idx;
    tracker_d    = tracker;
    mask_d       = mask;
    scan_len_d   = scan_len;
    scan_start_d = scan_start;
    cand         = '0;
    busy_d       = busy;
    done_d       = done;
    cal_ok_d     = cal_ok;
    best_d       = best_phase;
    len_d        = window_len;
    updn_d       = phase_updn;

    if (!pll_locked && (state inside {SETTLE, TEST, STEP_HI, STEP_LO, EVAL,
                                      MOVE_HI, MOVE_LO, MOVE_SETTLE})) begin
      state_d = FAIL;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_d  = WAIT_LOCK;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          cal_ok_d = 1'b0;
          mask_d   = '0;
          idx_d    = '0;
          updn_d   = 1'b1;
        end
        WAIT_LOCK: if (pll_locked) state_d = SETTLE;
        SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_d = TEST;
        TEST: begin
          if (test_ack) begin
            mask_d[idx] = test_pass;
            state_d     = STEP_HI;
          end else if (cnt == CNT_W'(TEST_TIMEOUT - 1)) begin
            mask_d[idx] = 1'b0;
            state_d     = STEP_HI;
          end
        end
        STEP_HI: if (cnt == CNT_W'(STEP_PULSE_CYCLES - 1)) state_d = STEP_LO;
        STEP_LO: if (cnt == CNT_W'(STEP_PULSE_CYCLES - 1)) begin
          tracker_d    = tracker + 3'd1;
          idx_d        = idx + 3'd1;
          scan_len_d   = '0;
          scan_start_d = '0;
          state_d      = (idx == 3'd7) ? EVAL : SETTLE;
        end
        // One candidate start per cycle, then a result cycle, then a branch cycle
        EVAL: begin
          if (cnt < CNT_W'(NUM_PHASES)) begin
            cand = run_len(mask, cnt[2:0]);
            if (cand > scan_len) begin
              scan_len_d   = cand;
              scan_start_d = cnt[2:0];
            end
          end else if (cnt == CNT_W'(NUM_PHASES)) begin
            if (mask == '0) begin
              state_d = FAIL;
            end else begin
              if (&mask) begin
                best_d = '0;
                len_d  = 4'd8;
              end else begin
                best_d = scan_start + 3'((scan_len - 4'd1) >> 1);
                len_d  = scan_len;
              end
              updn_d = (best_d <= 3'd4);
            end
          end else begin
            state_d = (best_phase == tracker) ? DONE : MOVE_HI;
          end
        end
        MOVE_HI: if (cnt == CNT_W'(STEP_PULSE_CYCLES - 1)) state_d = MOVE_LO;
        MOVE_LO: if (cnt == CNT_W'(STEP_PULSE_CYCLES - 1)) begin
          tracker_d = phase_updn ? tracker + 3'd1 : tracker - 3'd1;
          state_d   = MOVE_SETTLE;
        end
        MOVE_SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1))
          state_d = (tracker == best_phase) ? DONE : MOVE_HI;
        DONE:    state_d = IDLE;
        FAIL:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state) cnt_d = '0;

    if (state_d == DONE) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      cal_ok_d = 1'b1;
    end else if (state_d == FAIL) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      cal_ok_d = 1'b0;
      best_d   = '0;
      len_d    = '0;
    end

    step_d = (state_d == STEP_HI) || (state_d == MOVE_HI);
    req_d  = (state_d == TEST);
  end

`ifdef DDR_CAL_DEBUG_EN
  assign pass_mask = mask;
`endif

endmodule

// File: doc/ddr_read_phase_cal.md
Name: ddr_read_phase_cal

Overview:
- Read-DQS phase calibration sequencer for the DDR3 PHY.
- Drives the step-based phase facade of the clocking block (phase_step/phase_updn) through all 8 read-clock phase positions and runs one test read burst per position via a req/ack handshake with the read datapath.
- Finds the longest circular passing window, then steps the read clock to the window centre.
- Sits between the clocking block and the PHY init sequencer, which pulses start after DDR3 init.

Parameters:
- NUM_PHASES, 8, phase positions per 360° (fixed: 3-bit phase tracker).
- SETTLE_CYCLES, 64, clk cycles waited after each phase step before testing.
- STEP_PULSE_CYCLES, 4, cycles phase_step is held high, and then held low, per step.
- TEST_TIMEOUT, 1024, cycles without test_ack before a test counts as a fail.

Ports:
- clk  in  1  system clock (same clock as the clocking block's step logic).
- rst  in  1  reset.
- start  in  1  one-cycle pulse that begins calibration.
- pll_locked  in  1  both PLLs locked.
- phase_step  out  1  step strobe to the clocking block.
- phase_updn  out  1  step direction: 1 = up, 0 = down.
- test_req  out  1  request one test read burst.
- test_ack  in  1  one-cycle pulse: test complete.
- test_pass  in  1  test result, valid with test_ack.
- busy  out  1  calibration in progress.
- done  out  1  calibration finished (sticky until the next start).
- cal_ok  out  1  a passing window was found; valid when done=1.
- best_phase  out  3  selected phase, relative to reset phase 0.
- window_len  out  4  passing window length, 0..8.

Behaviour:
- Reset: synchronous, active-high rst; clock clk.
- Reset values: all outputs 0; internal phase tracker 0 (matches the clocking block's reset phase); pass mask 0.
- States: IDLE, WAIT_LOCK, SETTLE, TEST, STEP_HI, STEP_LO, EVAL, MOVE_HI, MOVE_LO, MOVE_SETTLE, DONE, FAIL.
- IDLE:
  - start=1 → WAIT_LOCK; busy=1, done=0, cal_ok=0, mask cleared, sweep index i=0.
  - start is ignored in every other state.
- WAIT_LOCK: wait for pll_locked=1, then → SETTLE.
- SETTLE: count SETTLE_CYCLES, then → TEST.
- TEST:
  - test_req=1, held until test_ack.
  - On test_ack: mask[i] <= test_pass; test_req drops the next cycle.
  - If TEST_TIMEOUT cycles elapse without ack: mask[i] <= 0, test_req drops.
  - Then, if i<7 → STEP_HI; if i=7 → STEP_HI as well (the 8th step wraps the phase back to 0), then → EVAL.
- STEP_HI / STEP_LO:
  - phase_updn=1; phase_step high for STEP_PULSE_CYCLES, then low for STEP_PULSE_CYCLES.
  - Tracker +1 mod 8; i+1.
  - After STEP_LO → SETTLE, or → EVAL when wrapping past i=7.
- EVAL (may take up to 16 cycles, iterative scan):
  - Find the longest circular run of 1s in mask; ties go to the lowest start index.
  - window_len = run length.
  - best_phase = (start + (len-1)/2) mod 8.
  - mask=0 → FAIL.
  - mask=8'hFF → window_len=8, best_phase=0.
- MOVE:
  - Shortest path from phase 0: best_phase ≤ 4 → best_phase up-steps; otherwise 8-best_phase down-steps (phase_updn=0).
  - Each step uses the same HI/LO pulse timing, followed by SETTLE_CYCLES in MOVE_SETTLE.
  - Zero steps needed → straight to DONE.
- DONE: busy=0, done=1, cal_ok=1 → IDLE (done stays 1 until the next start).
- FAIL: busy=0, done=1, cal_ok=0, best_phase=0, window_len=0 → IDLE.
- Lock loss: pll_locked=0 in any state other than IDLE, WAIT_LOCK, DONE or FAIL → FAIL next cycle; test_req and phase_step drop immediately.
- phase_updn changes only while phase_step=0.
- rst mid-operation: immediate return to reset values; no partial pulse continues.

Optional Feature:
- Macro: DDR_CAL_DEBUG_EN.
- Defined: adds output port pass_mask [7:0] = the sweep result mask, updated as each bit is written and held after DONE/FAIL.
- Not defined: port absent; behaviour otherwise identical.

Test Plan:
- Passing positions 2..5 (mask 8'h3C) → window_len=4, best_phase=3, three up-steps after the sweep, done=1, cal_ok=1.
- Mask 8'hC1 (positions 6,7,0) → circular window from 6, len 3, best_phase=7, one down-step issued.
- All tests fail → FAIL: done=1, cal_ok=0, window_len=0, exactly 8 up-steps in total, no move steps.
- test_ack never arrives at position 4 (others pass) → after TEST_TIMEOUT, mask[4]=0; window 5..3 circular, len 7, best_phase=0, no move.
- pll_locked drops during SETTLE at i=3 → FAIL within 1 cycle, test_req=0, phase_step=0, cal_ok=0.
- start pulsed while busy=1 → ignored; the sweep completes once with exactly 8 sweep step pulses, each high for 4 cycles.
